// File: rtl/pcpu_run_ctrl_if.sv
// Control bundle between the run controller and the pipelined-CPU top.
// master = the run controller; slave = the CPU/board side.
interface pcpu_run_ctrl_if;
    logic btn_start;
    logic pause;
    logic halt;
    logic clk_reset;
    logic cpu_reset;
    logic mem_reset;
    logic enable;
    logic start;
    logic ready;
    logic running;

    modport master (
        input  btn_start, pause, halt,
        output clk_reset, cpu_reset, mem_reset, enable, start, ready, running
    );

    modport slave (
        output btn_start, pause, halt,
        input  clk_reset, cpu_reset, mem_reset, enable, start, ready, running
    );
endinterface

// File: rtl/pcpu_run_ctrl.sv
// Run controller for the pipelined CPU: staged reset release, enable gating,
// debounced start button producing a fixed-width start pulse, halt -> idle.
module pcpu_run_ctrl #(
    parameter int unsigned GAP      = 25,
    parameter int unsigned HOLD     = 25,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic            clock,
    input  logic            reset,
    pcpu_run_ctrl_if.master bus
);
    localparam int unsigned MAX_T = (GAP > HOLD) ? GAP : HOLD;
    localparam int unsigned CW    = $clog2(MAX_T) + 1;
    localparam int unsigned DW    = $clog2(DEBOUNCE) + 1;

    typedef enum logic [2:0] {
        S_HOLD_ALL = 3'd0,
        S_REL_CLK  = 3'd1,
        S_REL_CPU  = 3'd2,
        S_REL_MEM  = 3'd3,
        S_IDLE     = 3'd4,
        S_PULSE    = 3'd5,
        S_RUN      = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   limit_c;
    logic            timeout_c;

    logic            sync1, sync2, db, db_d, press;
    logic [DW-1:0]   db_cnt;

    logic clk_reset_d, cpu_reset_d, mem_reset_d, enable_d, start_d, ready_d, running_d;
    logic clk_reset_q, cpu_reset_q, mem_reset_q, enable_q, start_q, ready_q, running_q;

    // Button: two-flop synchroniser, stability debouncer, one-cycle rising-edge event
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db     <= 1'b0;
            db_d   <= 1'b0;
            press  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= bus.btn_start;
            sync2 <= sync1;
            db_d  <= db;
            press <= db & ~db_d;
            if (sync2 != db) begin
                if (db_cnt == DW'(DEBOUNCE - 1)) begin
                    db     <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_comb begin
        limit_c   = (state == S_PULSE) ? CW'(HOLD - 1) : CW'(GAP - 1);
        timeout_c = (cnt == limit_c);
    end

    // State register and phase counter (cleared on every state entry)
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_HOLD_ALL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || (state == S_IDLE) || (state == S_RUN))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    // Next-state logic; presses outside IDLE are simply dropped
    always_comb begin
        state_nxt = state;
        case (state)
            S_HOLD_ALL: if (timeout_c) state_nxt = S_REL_CLK;
            S_REL_CLK:  if (timeout_c) state_nxt = S_REL_CPU;
            S_REL_CPU:  if (timeout_c) state_nxt = S_REL_MEM;
            S_REL_MEM:  if (timeout_c) state_nxt = S_IDLE;
            S_IDLE:     if (press)     state_nxt = S_PULSE;
            S_PULSE:    if (timeout_c) state_nxt = S_RUN;
            S_RUN:      if (bus.halt)  state_nxt = S_IDLE;
            default:                   state_nxt = S_HOLD_ALL;
        endcase
    end

    // Output decode from the next state so the registered outputs track state
    always_comb begin
        clk_reset_d = (state_nxt == S_HOLD_ALL);
        cpu_reset_d = (state_nxt == S_HOLD_ALL) || (state_nxt == S_REL_CLK);
        mem_reset_d = (state_nxt == S_HOLD_ALL) || (state_nxt == S_REL_CLK) ||
                      (state_nxt == S_REL_CPU);
        enable_d    = ~bus.pause;
        start_d     = (state_nxt == S_PULSE);
        ready_d     = (state_nxt == S_IDLE);
        running_d   = (state_nxt == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_reset_q <= 1'b1;
            cpu_reset_q <= 1'b1;
            mem_reset_q <= 1'b1;
            enable_q    <= 1'b0;
            start_q     <= 1'b0;
            ready_q     <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            clk_reset_q <= clk_reset_d;
            cpu_reset_q <= cpu_reset_d;
            mem_reset_q <= mem_reset_d;
            enable_q    <= enable_d;
            start_q     <= start_d;
            ready_q     <= ready_d;
            running_q   <= running_d;
        end
    end

    assign bus.clk_reset = clk_reset_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.mem_reset = mem_reset_q;
    assign bus.enable    = enable_q;
    assign bus.start     = start_q;
    assign bus.ready     = ready_q;
    assign bus.running   = running_q;
endmodule

// File: tb/tb_pcpu_run_ctrl.sv
// Bench for pcpu_run_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a time-based behavioural model.
module tb_pcpu_run_ctrl;
    localparam int unsigned GAP      = 25;
    localparam int unsigned HOLD     = 25;
    localparam int unsigned DEBOUNCE = 4;

    localparam int M_SEQ   = 0;
    localparam int M_IDLE  = 1;
    localparam int M_PULSE = 2;
    localparam int M_RUN   = 3;

    logic clock = 1'b0;
    logic tb_reset = 1'b1;
    logic tb_btn = 1'b0;
    logic tb_pause = 1'b0;
    logic tb_halt = 1'b0;

    always #5 clock = ~clock;

    pcpu_run_ctrl_if bus ();
    assign bus.btn_start = tb_btn;
    assign bus.pause     = tb_pause;
    assign bus.halt      = tb_halt;

    pcpu_run_ctrl #(.GAP(GAP), .HOLD(HOLD), .DEBOUNCE(DEBOUNCE)) dut (
        .clock (clock),
        .reset (tb_reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: edges since release, run mode, and the button history in time
    int m_n, m_mode, m_pulse, m_run;
    bit s1, s2, m_db, d1, d2, d3, e_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic b, input logic p, input logic h);
        bit press_now;
        if (r) begin
            m_n = 0; m_mode = M_SEQ; m_pulse = 0; m_run = 0;
            s1 = 0; s2 = 0; m_db = 0; d1 = 0; d2 = 0; d3 = 0; e_en = 0;
        end else begin
            // button seen by the FSM two cycles after the debounced level rose
            press_now = d2 && !d3;
            if (s2 != m_db) begin
                m_run++;
                if (m_run == int'(DEBOUNCE)) begin
                    m_db  = s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            d3 = d2; d2 = d1; d1 = m_db;
            s2 = s1; s1 = b;
            if (m_n < int'(4 * GAP)) m_n++;
            case (m_mode)
                M_SEQ:   if (m_n >= int'(4 * GAP)) m_mode = M_IDLE;
                M_IDLE:  if (press_now) begin m_mode = M_PULSE; m_pulse = int'(HOLD); end
                M_PULSE: begin m_pulse--; if (m_pulse == 0) m_mode = M_RUN; end
                M_RUN:   if (h) m_mode = M_IDLE;
                default: m_mode = M_SEQ;
            endcase
            e_en = !p;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_step(tb_reset, tb_btn, tb_pause, tb_halt);
        cyc++;
        check($sformatf("clk_reset@%0d", cyc), 32'(bus.clk_reset), 32'(m_n < int'(GAP)));
        check($sformatf("cpu_reset@%0d", cyc), 32'(bus.cpu_reset), 32'(m_n < int'(2 * GAP)));
        check($sformatf("mem_reset@%0d", cyc), 32'(bus.mem_reset), 32'(m_n < int'(3 * GAP)));
        check($sformatf("enable@%0d", cyc),    32'(bus.enable),    32'(e_en));
        check($sformatf("start@%0d", cyc),     32'(bus.start),     32'(m_mode == M_PULSE));
        check($sformatf("ready@%0d", cyc),     32'(bus.ready),     32'(m_mode == M_IDLE));
        check($sformatf("running@%0d", cyc),   32'(bus.running),   32'(m_mode == M_RUN));
    endtask

    // Runs a release sequence; returns first cycles each reset fell / ready rose
    task automatic release_seq(input int pause_from, input int pause_to,
                               output int t_clk, output int t_cpu, output int t_mem,
                               output int t_rdy, output int n_dis);
        t_clk = -1; t_cpu = -1; t_mem = -1; t_rdy = -1; n_dis = 0;
        for (int i = 0; i < 110; i++) begin
            tb_pause = (i >= pause_from) && (i < pause_to);
            tick();
            if (t_clk < 0 && bus.clk_reset === 1'b0) t_clk = i + 1;
            if (t_cpu < 0 && bus.cpu_reset === 1'b0) t_cpu = i + 1;
            if (t_mem < 0 && bus.mem_reset === 1'b0) t_mem = i + 1;
            if (t_rdy < 0 && bus.ready === 1'b1)     t_rdy = i + 1;
            if (bus.enable === 1'b0) n_dis++;
        end
        tb_pause = 1'b0;
    endtask

    // Holds the button for hold_cycles, returns start latency and total width
    task automatic press(input int hold_cycles, input int span,
                         output int lat, output int width);
        lat = -1; width = 0;
        tb_btn = 1'b1;
        for (int j = 0; j < span; j++) begin
            tick();
            if (j == hold_cycles - 1) tb_btn = 1'b0;
            if (bus.start === 1'b1) begin
                if (lat < 0) lat = j;
                width++;
            end
        end
        tb_btn = 1'b0;
    endtask

    initial begin
        int t_clk, t_cpu, t_mem, t_rdy, n_dis, lat, width, hold_left;

        repeat (3) tick();
        check("reset_start", 32'(bus.start), 32'd0);
        check("reset_enable", 32'(bus.enable), 32'd0);
        tb_reset = 1'b0;

        // release sequence timing
        release_seq(-1, -1, t_clk, t_cpu, t_mem, t_rdy, n_dis);
        check("clk_reset_fall", 32'(t_clk), 32'd25);
        check("cpu_reset_fall", 32'(t_cpu), 32'd50);
        check("mem_reset_fall", 32'(t_mem), 32'd75);
        check("ready_rise", 32'(t_rdy), 32'd100);
        check("enable_low_cycles", 32'(n_dis), 32'd0);

        // clean press held for 20 cycles
        press(20, 60, lat, width);
        check("start_latency", 32'(lat), 32'd7);
        check("start_width", 32'(width), 32'd25);
        check("running_after_pulse", 32'(bus.running), 32'd1);

        // halt from RUN
        tb_halt = 1'b1; tick(); tb_halt = 1'b0;
        check("halt_running", 32'(bus.running), 32'd0);
        check("halt_ready", 32'(bus.ready), 32'd1);

        // bounces shorter than the debounce window
        width = 0;
        for (int j = 0; j < 24; j++) begin
            tb_btn = (j < 8) && ((j % 4) < 2);
            tick();
            if (bus.start === 1'b1) width++;
        end
        tb_btn = 1'b0;
        check("bounce_no_start", 32'(width), 32'd0);
        check("bounce_ready", 32'(bus.ready), 32'd1);

        // second press after halt
        press(40, 50, lat, width);
        check("second_latency", 32'(lat), 32'd7);
        check("second_width", 32'(width), 32'd25);

        // reset in the middle of a start pulse
        tb_halt = 1'b1; tick(); tb_halt = 1'b0;
        tb_btn = 1'b1;
        for (int j = 0; j < 20 && bus.start !== 1'b1; j++) tick();
        check("pulse_seen", 32'(bus.start), 32'd1);
        repeat (9) tick();
        tb_reset = 1'b1; tick(); tb_reset = 1'b0; tb_btn = 1'b0;
        check("midreset_start", 32'(bus.start), 32'd0);
        check("midreset_resets", 32'({bus.clk_reset, bus.cpu_reset, bus.mem_reset}), 32'd7);
        check("midreset_enable", 32'(bus.enable), 32'd0);

        // release again with 30 cycles of pause starting in REL_CPU
        release_seq(51, 81, t_clk, t_cpu, t_mem, t_rdy, n_dis);
        check("pause_mem_fall", 32'(t_mem), 32'd75);
        check("pause_ready", 32'(t_rdy), 32'd100);
        check("pause_cycles", 32'(n_dis), 32'd30);

        // randomized operation against the model
        hold_left = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold_left == 0) begin
                tb_btn    = 1'($urandom_range(0, 1));
                hold_left = int'($urandom_range(1, 12));
            end
            hold_left--;
            tb_pause = ($urandom_range(0, 9) == 0);
            tb_halt  = ($urandom_range(0, 19) == 0);
            tb_reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        tb_reset = 1'b0; tb_pause = 1'b0; tb_halt = 1'b0; tb_btn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
